// File: rtl/datapath_p_pkg.sv
// Shared definitions for the datapath core: ALU opcodes, memory FSM states,
// flag layout and the fixed Xbus select offsets.
package datapath_p_pkg;

  localparam int PC_SEL   = 0;
  localparam int GPR_BASE = 1;

  // Codes 14 and 15 are unassigned and behave as PASSA.
  typedef enum logic [3:0] {
    ALU_PASSA = 4'h0,
    ALU_PASSB = 4'h1,
    ALU_ADD   = 4'h2,
    ALU_ADC   = 4'h3,
    ALU_SUB   = 4'h4,
    ALU_SBC   = 4'h5,
    ALU_AND   = 4'h6,
    ALU_OR    = 4'h7,
    ALU_XOR   = 4'h8,
    ALU_NOT   = 4'h9,
    ALU_INC   = 4'hA,
    ALU_DEC   = 4'hB,
    ALU_SHL   = 4'hC,
    ALU_SHR   = 4'hD
  } aluop_t;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_st_t;

  typedef struct packed {
    logic s;
    logic z;
    logic cy;
  } flags_t;

endpackage

// File: rtl/datapath_core_p_alu.sv
// Combinational ALU. Cy is carry-out for add/inc, borrow for sub/dec,
// the shifted-out bit for shifts, and passes Cy_in through for logic/pass ops.
module alu_p
  import datapath_p_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cy_in,
  input  logic [3:0]    op,
  output logic [DW-1:0] y,
  output flags_t        flags
);

  logic [DW:0] ext;
  logic [DW:0] a_x, b_x, c_x, one_x;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign c_x   = {{DW{1'b0}}, cy_in};
  assign one_x = {{DW{1'b0}}, 1'b1};

  // ext[DW] is the carry/borrow slot; subtraction wraps into it on borrow.
  always_comb begin
    ext = {cy_in, a};
    case (op)
      ALU_PASSA: ext = {cy_in, a};
      ALU_PASSB: ext = {cy_in, b};
      ALU_ADD:   ext = a_x + b_x;
      ALU_ADC:   ext = a_x + b_x + c_x;
      ALU_SUB:   ext = a_x - b_x;
      ALU_SBC:   ext = a_x - b_x - c_x;
      ALU_AND:   ext = {cy_in, a & b};
      ALU_OR:    ext = {cy_in, a | b};
      ALU_XOR:   ext = {cy_in, a ^ b};
      ALU_NOT:   ext = {cy_in, ~a};
      ALU_INC:   ext = a_x + one_x;
      ALU_DEC:   ext = a_x - one_x;
      ALU_SHL:   ext = {a, 1'b0};
      ALU_SHR:   ext = {a[0], 1'b0, a[DW-1:1]};
      default:   ext = {cy_in, a};
    endcase
  end

  assign y     = ext[DW-1:0];
  assign flags = {ext[DW-1], ~|ext[DW-1:0], ext[DW]};

endmodule

// File: rtl/datapath_core_p.sv
// Register-file datapath around a shared Xbus, with a combinational ALU
// and a three-state memory handshake FSM (read/write request, wait for ack).
module datapath_core_p
  import datapath_p_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NGPR = 3,
  parameter int SELW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [DW-1:0]   RD,
  input  logic            mem_ack,
  output logic [DW-1:0]   MA,
  output logic [DW-1:0]   WD,
  output logic            mem_re,
  output logic            mem_we,
  input  logic [SELW-1:0] xsrc,
  input  logic [SELW-1:0] xdst,
  input  logic [3:0]      aluop,
  input  logic            Rwe,
  input  logic            FLGwe,
  input  logic            mem_rd,
  input  logic            mem_wr,
  output logic            busy,
  output logic [DW-1:0]   I,
  output logic [2:0]      SZCy,
  input  logic [SELW-1:0] dbg_addr,
  output logic [DW-1:0]   dbg_data
);

  localparam int NSRC = 2 ** SELW;

  localparam logic [SELW-1:0] SRC_R   = SELW'(NGPR + 1);
  localparam logic [SELW-1:0] SRC_RDR = SELW'(NGPR + 2);
  localparam logic [SELW-1:0] SRC_FLG = SELW'(NGPR + 3);
  localparam logic [SELW-1:0] DST_PC  = SELW'(PC_SEL);
  localparam logic [SELW-1:0] DST_MAR = SELW'(NGPR + 1);
  localparam logic [SELW-1:0] DST_WDR = SELW'(NGPR + 2);
  localparam logic [SELW-1:0] DST_T   = SELW'(NGPR + 3);
  localparam logic [SELW-1:0] DST_I   = SELW'(NGPR + 4);

  logic [DW-1:0]            pc, t, r, mar, wdr, rdr, ir, flg;
  logic [NGPR-1:0][DW-1:0]  gpr;
  logic [NSRC-1:0][DW-1:0]  src;
  logic [DW-1:0]            xbus, alu_y;
  flags_t                   alu_fl;
  mem_st_t                  st;
  logic                     wr_en;

  // Source table shared by the Xbus and the debug port; unused codes read all-ones.
  always_comb begin
    src = '1;
    src[PC_SEL] = pc;
    for (int k = 0; k < NGPR; k++) src[GPR_BASE + k] = gpr[k];
    src[SRC_R]   = r;
    src[SRC_RDR] = rdr;
    src[SRC_FLG] = flg;
  end

  assign xbus     = src[xsrc];
  assign dbg_data = src[dbg_addr];

  alu_p #(.DW(DW)) u_alu (
    .a     (xbus),
    .b     (t),
    .cy_in (flg[0]),
    .op    (aluop),
    .y     (alu_y),
    .flags (alu_fl)
  );

  // MAR/WDR can only change through Xbus writes, so gating on busy keeps them stable.
  assign wr_en = Rwe & ~busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc  <= '0;
      gpr <= '0;
      t   <= '0;
      r   <= '0;
      mar <= '0;
      wdr <= '0;
      ir  <= '0;
      flg <= '0;
      rdr <= '0;
    end else begin
      if (FLGwe) flg <= DW'(alu_fl);
      if (wr_en) begin
        if (xdst == DST_PC)  pc  <= xbus;
        if (xdst == DST_MAR) mar <= xbus;
        if (xdst == DST_WDR) wdr <= xbus;
        if (xdst == DST_I)   ir  <= xbus;
        if (xdst == DST_T) begin
          t <= xbus;
          r <= alu_y;
        end
        for (int k = 0; k < NGPR; k++)
          if (xdst == SELW'(GPR_BASE + k)) gpr[k] <= xbus;
      end
      if (st == MEM_RD_WAIT && mem_ack) rdr <= RD;
    end
  end

  // Strobes are registered alongside the state so they drop with the async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st     <= MEM_IDLE;
      busy   <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      case (st)
        MEM_IDLE: begin
          if (mem_rd) begin
            st     <= MEM_RD_WAIT;
            busy   <= 1'b1;
            mem_re <= 1'b1;
          end else if (mem_wr) begin
            st     <= MEM_WR_WAIT;
            busy   <= 1'b1;
            mem_we <= 1'b1;
          end
        end
        MEM_RD_WAIT: begin
          if (mem_ack) begin
            st     <= MEM_IDLE;
            busy   <= 1'b0;
            mem_re <= 1'b0;
          end
        end
        MEM_WR_WAIT: begin
          if (mem_ack) begin
            st     <= MEM_IDLE;
            busy   <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        default: begin
          st     <= MEM_IDLE;
          busy   <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign MA   = mar;
  assign WD   = wdr;
  assign I    = ir;
  assign SZCy = flg[2:0];

endmodule

// File: tb/tb_datapath_core_p.sv
// Random + directed bench for datapath_core_p against an abstract register/ALU model,
// plus a wide (DW=16, NGPR=6) instance for the debug readback case.
module tb_datapath_core_p;
  import datapath_p_pkg::*;

  localparam int DW = 8, NGPR = 3, SELW = 3;
  localparam int MSK = (1 << DW) - 1;
  localparam int WDW = 16, WNGPR = 6, WSELW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #20 clock = ~clock;

  logic [DW-1:0]   RD, MA, WD, I, dbg_data;
  logic            mem_ack, mem_re, mem_we, Rwe, FLGwe, mem_rd, mem_wr, busy;
  logic [SELW-1:0] xsrc, xdst, dbg_addr;
  logic [3:0]      aluop;
  logic [2:0]      SZCy;

  logic [WDW-1:0]   w_RD, w_MA, w_WD, w_I, w_dbg_data;
  logic             w_mem_ack, w_mem_re, w_mem_we, w_Rwe, w_FLGwe, w_mem_rd, w_mem_wr, w_busy;
  logic [WSELW-1:0] w_xsrc, w_xdst, w_dbg_addr;
  logic [3:0]       w_aluop;
  logic [2:0]       w_SZCy;

  datapath_core_p #(.DW(DW), .NGPR(NGPR), .SELW(SELW)) u_dut (
    .clock(clock), .reset(reset), .RD(RD), .mem_ack(mem_ack), .MA(MA), .WD(WD),
    .mem_re(mem_re), .mem_we(mem_we), .xsrc(xsrc), .xdst(xdst), .aluop(aluop),
    .Rwe(Rwe), .FLGwe(FLGwe), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy),
    .I(I), .SZCy(SZCy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  datapath_core_p #(.DW(WDW), .NGPR(WNGPR), .SELW(WSELW)) u_wide (
    .clock(clock), .reset(reset), .RD(w_RD), .mem_ack(w_mem_ack), .MA(w_MA), .WD(w_WD),
    .mem_re(w_mem_re), .mem_we(w_mem_we), .xsrc(w_xsrc), .xdst(w_xdst), .aluop(w_aluop),
    .Rwe(w_Rwe), .FLGwe(w_FLGwe), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr), .busy(w_busy),
    .I(w_I), .SZCy(w_SZCy), .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Abstract model: named registers plus a transfer mode (0 none, 1 read, 2 write).
  int m_pc, m_t, m_r, m_mar, m_wdr, m_rdr, m_i, m_flg, m_mode;
  int m_g[NGPR];

  function automatic int m_src(input int sel);
    if (sel == 0) return m_pc;
    if (sel >= 1 && sel <= NGPR) return m_g[sel-1];
    if (sel == NGPR+1) return m_r;
    if (sel == NGPR+2) return m_rdr;
    if (sel == NGPR+3) return m_flg;
    return MSK;
  endfunction

  function automatic void alu_ref(input int op, input int a, input int b, input int ci,
                                  output int y, output int fl);
    int s, cy;
    cy = ci;
    case (op)
      ALU_PASSB: y = b;
      ALU_ADD: begin s = a + b;      y = s & MSK; cy = (s > MSK); end
      ALU_ADC: begin s = a + b + ci; y = s & MSK; cy = (s > MSK); end
      ALU_SUB: begin s = a - b;      y = s & MSK; cy = (s < 0); end
      ALU_SBC: begin s = a - b - ci; y = s & MSK; cy = (s < 0); end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = (~a) & MSK;
      ALU_INC: begin y = (a + 1) & MSK; cy = (a == MSK); end
      ALU_DEC: begin y = (a - 1) & MSK; cy = (a == 0); end
      ALU_SHL: begin y = (a * 2) & MSK; cy = (a >> (DW-1)) & 1; end
      ALU_SHR: begin y = a / 2; cy = a % 2; end
      default: y = a;
    endcase
    fl = ((y >> (DW-1)) & 1) * 4 + (y == 0) * 2 + cy;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_t = 0; m_r = 0; m_mar = 0; m_wdr = 0; m_rdr = 0; m_i = 0; m_flg = 0; m_mode = 0;
    for (int k = 0; k < NGPR; k++) m_g[k] = 0;
  endtask

  task automatic model_step();
    int xb, y, fl, xd;
    bit bsy;
    xb = m_src(int'(xsrc));
    xd = int'(xdst);
    alu_ref(int'(aluop), xb, m_t, m_flg & 1, y, fl);
    bsy = (m_mode != 0);
    if (FLGwe) m_flg = fl;
    if (Rwe && !bsy) begin
      if (xd == 0) m_pc = xb;
      else if (xd <= NGPR) m_g[xd-1] = xb;
      else if (xd == NGPR+1) m_mar = xb;
      else if (xd == NGPR+2) m_wdr = xb;
      else if (xd == NGPR+3) begin m_t = xb; m_r = y; end
      else if (xd == NGPR+4) m_i = xb;
    end
    case (m_mode)
      0: if (mem_rd) m_mode = 1; else if (mem_wr) m_mode = 2;
      1: if (mem_ack) begin m_rdr = int'(RD); m_mode = 0; end
      default: if (mem_ack) m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_mode != 0);
    chk("mem_re", mem_re, m_mode == 1);
    chk("mem_we", mem_we, m_mode == 2);
    chk("MA", MA, m_mar);
    chk("WD", WD, m_wdr);
    chk("I", I, m_i);
    chk("SZCy", SZCy, m_flg & 7);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = SELW'(a);
      #1;
      chk($sformatf("dbg%0d", a), dbg_data, m_src(a));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic drv(input int xs, input int xd, input int op, input int rwe, input int fwe,
                     input int rd, input int wr, input int ack, input int rdata);
    xsrc = SELW'(xs); xdst = SELW'(xd); aluop = 4'(op);
    Rwe = (rwe != 0); FLGwe = (fwe != 0); mem_rd = (rd != 0); mem_wr = (wr != 0);
    mem_ack = (ack != 0); RD = DW'(rdata);
  endtask

  task automatic peek(input int sel, output logic [DW-1:0] v);
    dbg_addr = SELW'(sel);
    #1;
    v = dbg_data;
  endtask

  task automatic load_rdr(input int val);
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, val); step();
  endtask

  localparam int S_RDR = NGPR + 2, D_G0 = 1, D_MAR = NGPR + 1;

  initial begin
    logic [DW-1:0] v;
    int nb, nre, nwe;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dbg_addr = '0;
    w_RD = '0; w_mem_ack = 0; w_xsrc = '0; w_xdst = '0; w_aluop = '0; w_Rwe = 0;
    w_FLGwe = 0; w_mem_rd = 0; w_mem_wr = 0; w_dbg_addr = '0;
    model_reset();
    #5;
    check_outputs();
    @(negedge clock);
    reset = 1'b0;

    // All-ones source into G0, then a masked write must not disturb it.
    drv(7, D_G0, 0, 1, 0, 0, 0, 0, 0); step();
    peek(D_G0, v); chk("g0_ones", v, 8'hFF);
    drv(0, D_G0, 0, 0, 0, 0, 0, 0, 0); step();
    peek(D_G0, v); chk("g0_rwe0", v, 8'hFF);

    // Read with three wait cycles from MAR=0x40.
    load_rdr(8'h40);
    drv(S_RDR, D_MAR, 0, 1, 0, 0, 0, 0, 0); step();
    nb = 0; nre = 0;
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0); step(); nb += busy; nre += mem_re;
    repeat (3) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); nb += busy; nre += mem_re;
      chk("ma_hold", MA, 8'h40);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 8'h5A); step(); nb += busy; nre += mem_re;
    chk("busy_cycles", nb, 4);
    chk("re_cycles", nre, 4);
    peek(S_RDR, v); chk("rdr_5a", v, 8'h5A);

    // Simultaneous read and write: read wins, write is dropped.
    nwe = 0;
    drv(0, 0, 0, 0, 0, 1, 1, 0, 0); step(); nwe += mem_we;
    chk("both_re", mem_re, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); nwe += mem_we;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 8'h11); step(); nwe += mem_we;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); nwe += mem_we;
    chk("both_we", nwe, 0);

    // Writes blocked while busy, accepted the cycle after busy falls.
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drv(S_RDR, D_G0, 0, 1, 0, 0, 0, 0, 0); step();
    peek(D_G0, v); chk("busy_blk", v, 8'hFF);
    drv(S_RDR, D_G0, 0, 1, 0, 0, 0, 1, 8'h3C); step();
    peek(D_G0, v); chk("busy_blk_ack", v, 8'hFF);
    drv(S_RDR, D_G0, 0, 1, 0, 0, 0, 0, 0); step();
    peek(D_G0, v); chk("after_busy", v, 8'h3C);

    // Randomized traffic against the model.
    repeat (400) begin
      drv($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 255));
      step();
    end

    // Reset in the middle of a read: strobes drop at once, later ack ignored.
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    chk("pre_rst_re", mem_re, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_re", mem_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    check_outputs();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 8'hA5); step();
    peek(S_RDR, v); chk("rst_ack_rdr", v, 8'h00);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Wide instance: BEEF via memory read into RDR, then into G5.
    @(negedge clock); w_mem_rd = 1;
    @(negedge clock); w_mem_rd = 0; w_mem_ack = 1; w_RD = 16'hBEEF;
    @(negedge clock); w_mem_ack = 0; w_xsrc = 4'(WNGPR + 2); w_xdst = 4'd6; w_Rwe = 1;
    @(negedge clock); w_Rwe = 0; w_xsrc = '0; w_xdst = '0;
    w_dbg_addr = 4'd6; #1; chk("w_g5", w_dbg_data, 16'hBEEF);
    w_dbg_addr = 4'd1; #1; chk("w_g0", w_dbg_data, 16'h0000);
    w_dbg_addr = 4'd15; #1; chk("w_ones", w_dbg_data, 16'hFFFF);
    chk("w_busy", w_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
